// File: rtl/pipeline_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline hazard/sequencing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Defines the flush FSM state encoding (PCTRL_RUN / PCTRL_FLUSH), the
// default flush length, the scoreboard counter width and the register
// address width. It also defines the priority-row enum used by the top level.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_SIZE    = 5;
    localparam int SB_CNT_SIZE      = 2;
    localparam int FLUSH_CYCLES_DEF = 1;
    // FLUSH_CYCLES is limited to 1..7, so the reload value (FLUSH_CYCLES-1) fits in 3 bits.
    localparam int FLUSH_CNT_W      = 3;

    typedef enum logic {
        PCTRL_RUN   = 1'b0,
        PCTRL_FLUSH = 1'b1
    } pctrl_state_e;

    // Exactly one row of the issue/stall/flush priority table applies each cycle.
    typedef enum logic [2:0] {
        ROW_FLUSH  = 3'd0,
        ROW_MEM    = 3'd1,
        ROW_EXBUSY = 3'd2,
        ROW_HAZARD = 3'd3,
        ROW_ISSUE  = 3'd4
    } pctrl_row_e;

endpackage

// File: rtl/pipeline_ctrl_reg_scoreboard.sv
// Purpose: per-register in-flight writer counters (register scoreboard) with rs1/rs2 read ports and an rd-full flag.
// Latency: reads are combinational from registered counters; updates become visible the cycle after the inc/dec.
// Backpressure: none here; the caller must not increment a full counter (rd_full_o gates issue upstream).
//
// Ports: clk_i/reset_i (sync, active-high); inc_i/inc_rd_i count a new writer;
// dec_i/dec_rd_i retire one; rs1_i/rs2_i -> rs1_cnt_o/rs2_cnt_o; rd_i -> rd_full_o.
// Define SIMULATE to get an error message on a decrement of an empty counter.
module pipeline_ctrl_reg_scoreboard
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = SB_CNT_SIZE
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     inc_i,
    input  logic [REG_ADDR_SIZE-1:0] inc_rd_i,
    input  logic                     dec_i,
    input  logic [REG_ADDR_SIZE-1:0] dec_rd_i,
    input  logic [REG_ADDR_SIZE-1:0] rs1_i,
    input  logic [REG_ADDR_SIZE-1:0] rs2_i,
    input  logic [REG_ADDR_SIZE-1:0] rd_i,
    output logic [CNT_W-1:0]         rs1_cnt_o,
    output logic [CNT_W-1:0]         rs2_cnt_o,
    output logic                     rd_full_o
);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    always_comb begin
        cnt_d = cnt_q;
        // x0 is never tracked; its entry is held at zero so reads need no special case.
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            logic inc_hit;
            logic dec_hit;
            inc_hit = inc_i && (inc_rd_i == REG_ADDR_SIZE'(r));
            dec_hit = dec_i && (dec_rd_i == REG_ADDR_SIZE'(r));
            // A simultaneous new writer and retiring writer on one register cancel out.
            if (inc_hit && !dec_hit) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_hit && !inc_hit && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef SIMULATE
    always_ff @(posedge clk_i) begin
        if (!reset_i && dec_i && (dec_rd_i != '0) && (cnt_q[dec_rd_i] == '0)
            && !(inc_i && (inc_rd_i == dec_rd_i))) begin
            $error("reg_scoreboard: writeback to x%0d with no writer in flight", dec_rd_i);
        end
    end
`endif

    assign rs1_cnt_o = cnt_q[rs1_i];
    assign rs2_cnt_o = cnt_q[rs2_i];
    assign rd_full_o = (cnt_q[rd_i] == {CNT_W{1'b1}});

endmodule

// File: rtl/pipeline_ctrl.sv
// Purpose: pipeline hazard/sequencing controller -- issue decision, stage stalls/flushes and the post-redirect flush sequencer.
// Latency: all outputs are combinational from registered state and current inputs (0 cycles).
// Backpressure: mem_stall holds fetch/decode/execute, ex_busy or a RAW/WAW hazard holds fetch/decode; a redirect overrides every stall.
//
// Ports: clk_i, reset_i (sync, active-high); decode dec_* operands; ex_redirect_i/ex_busy_i/mem_stall_i;
// writeback wb_valid_i/wb_rd_i; outputs issue_o, stall_{fetch,decode,execute}_o,
// flush_{fetch,decode,execute}_o and flush_busy_o. Define PIPE_PERF_EN to add perf_* counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int CNT_W        = SB_CNT_SIZE,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     dec_valid_i,
    input  logic [REG_ADDR_SIZE-1:0] dec_rs1_i,
    input  logic [REG_ADDR_SIZE-1:0] dec_rs2_i,
    input  logic                     dec_uses_rs1_i,
    input  logic                     dec_uses_rs2_i,
    input  logic [REG_ADDR_SIZE-1:0] dec_rd_i,
    input  logic                     dec_writes_rd_i,
    input  logic                     ex_redirect_i,
    input  logic                     ex_busy_i,
    input  logic                     mem_stall_i,
    input  logic                     wb_valid_i,
    input  logic [REG_ADDR_SIZE-1:0] wb_rd_i,
    output logic                     issue_o,
    output logic                     stall_fetch_o,
    output logic                     stall_decode_o,
    output logic                     stall_execute_o,
    output logic                     flush_fetch_o,
    output logic                     flush_decode_o,
    output logic                     flush_execute_o,
    output logic                     flush_busy_o
`ifdef PIPE_PERF_EN
   ,output logic [31:0]              perf_stall_cycles_o,
    output logic [31:0]              perf_hazard_cycles_o,
    output logic [31:0]              perf_flush_events_o
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pctrl_state_e            state_q, state_d;
    logic [FLUSH_CNT_W-1:0]  fcnt_q, fcnt_d;
    pctrl_row_e              row;
    logic [CNT_W-1:0]        rs1_cnt, rs2_cnt;
    logic                    rd_full;
    logic                    raw_hazard, waw_full;

    pipeline_ctrl_reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_sb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .inc_i     (issue_o && dec_writes_rd_i && (dec_rd_i != '0)),
        .inc_rd_i  (dec_rd_i),
        .dec_i     (wb_valid_i && (wb_rd_i != '0)),
        .dec_rd_i  (wb_rd_i),
        .rs1_i     (dec_rs1_i),
        .rs2_i     (dec_rs2_i),
        .rd_i      (dec_rd_i),
        .rs1_cnt_o (rs1_cnt),
        .rs2_cnt_o (rs2_cnt),
        .rd_full_o (rd_full)
    );

    // Hazards use pre-edge counts: a same-cycle writeback does not unblock the reader.
    assign raw_hazard = dec_valid_i && ((dec_uses_rs1_i && (rs1_cnt != '0)) ||
                                        (dec_uses_rs2_i && (rs2_cnt != '0)));
    assign waw_full   = dec_valid_i && dec_writes_rd_i && (dec_rd_i != '0) && rd_full;

    // Flush sequencer. The redirect cycle itself flushes from RUN; FLUSH covers
    // the remaining FLUSH_CYCLES-1 cycles, so a 1-cycle flush never leaves RUN.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            PCTRL_RUN: begin
                if (ex_redirect_i && (FLUSH_LOAD != '0)) begin
                    state_d = PCTRL_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            PCTRL_FLUSH: begin
                if (ex_redirect_i) begin
                    fcnt_d = FLUSH_LOAD;
                end else if (fcnt_q <= FLUSH_CNT_W'(1)) begin
                    state_d = PCTRL_RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = PCTRL_RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= PCTRL_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        if (ex_redirect_i || (state_q == PCTRL_FLUSH)) row = ROW_FLUSH;
        else if (mem_stall_i)                          row = ROW_MEM;
        else if (ex_busy_i)                            row = ROW_EXBUSY;
        else if (raw_hazard || waw_full)               row = ROW_HAZARD;
        else                                           row = ROW_ISSUE;
    end

    always_comb begin
        issue_o         = 1'b0;
        stall_fetch_o   = 1'b0;
        stall_decode_o  = 1'b0;
        stall_execute_o = 1'b0;
        flush_fetch_o   = 1'b0;
        flush_decode_o  = 1'b0;
        flush_execute_o = 1'b0;
        flush_busy_o    = 1'b0;
        if (reset_i) begin
            flush_fetch_o   = 1'b1;
            flush_decode_o  = 1'b1;
            flush_execute_o = 1'b1;
        end else begin
            flush_busy_o = (state_q == PCTRL_FLUSH);
            case (row)
                ROW_FLUSH: begin
                    flush_fetch_o  = 1'b1;
                    flush_decode_o = 1'b1;
                end
                ROW_MEM: begin
                    stall_fetch_o   = 1'b1;
                    stall_decode_o  = 1'b1;
                    stall_execute_o = 1'b1;
                end
                ROW_EXBUSY: begin
                    stall_fetch_o  = 1'b1;
                    stall_decode_o = 1'b1;
                end
                ROW_HAZARD: begin
                    // Hold the front end and feed execute a bubble.
                    stall_fetch_o   = 1'b1;
                    stall_decode_o  = 1'b1;
                    flush_execute_o = 1'b1;
                end
                default: issue_o = dec_valid_i;
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_stall_cycles_o  <= '0;
            perf_hazard_cycles_o <= '0;
            perf_flush_events_o  <= '0;
        end else begin
            if ((row == ROW_MEM) || (row == ROW_EXBUSY) || (row == ROW_HAZARD))
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
            if (row == ROW_HAZARD)
                perf_hazard_cycles_o <= perf_hazard_cycles_o + 32'd1;
            if (ex_redirect_i)
                perf_flush_events_o <= perf_flush_events_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the in-order pipeline (fetch, decode, execute, mem, writeback). It tracks in-flight register writes in a per-register scoreboard and decides each cycle whether the decoded instruction may issue. It generates the stall and flush inputs consumed by fetch, decode and execute. It also runs a flush sequencer after control-flow redirects from execute.

Parameters:
NUM_REGS, 32, architectural registers; x0 is never tracked.
CNT_W, 2, per-register in-flight writer counter width; max outstanding writers per register is 2^CNT_W-1.
FLUSH_CYCLES, 1, cycles flush_fetch/flush_decode stay asserted after a redirect (1..7).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
dec_valid  in  1  decode holds a valid instruction
dec_rs1, dec_rs2  in  5 each  source register addresses
dec_uses_rs1, dec_uses_rs2  in  1 each  source actually read
dec_rd  in  5  destination register
dec_writes_rd  in  1  instruction writes rd
ex_redirect  in  1  taken branch/jump resolved in execute
ex_busy  in  1  multi-cycle execute op in progress
mem_stall  in  1  memory stage waiting
wb_valid  in  1  writeback retiring a register write
wb_rd  in  5  register being written back
issue  out  1  decode instruction accepted into execute this cycle
stall_fetch, stall_decode, stall_execute  out  1 each  hold stage registers
flush_fetch, flush_decode, flush_execute  out  1 each  invalidate stage output
flush_busy  out  1  flush sequencer not in RUN

Behaviour:
- All outputs are combinational from registered state plus current inputs (0-cycle latency). Stages sample them at the next posedge.
- During reset: issue=0, all stall_*=0, all flush_*=1, flush_busy=0. On the clock edge with reset high: scoreboard counters clear to 0, FSM goes to RUN, flush counter goes to 0. Reset mid-flush or mid-stall aborts immediately.
- Scoreboard: one CNT_W-bit counter per register 1..NUM_REGS-1.
  - Increment on issue && dec_writes_rd && dec_rd!=0.
  - Decrement on wb_valid && wb_rd!=0.
  - Increment and decrement on the same register in the same cycle: counter unchanged.
  - Register 0 always reads 0.
  - Decrement of a zero counter leaves it at 0. Under SIMULATE it prints an error.
- raw_hazard = dec_valid && ((dec_uses_rs1 && cnt[dec_rs1]!=0) || (dec_uses_rs2 && cnt[dec_rs2]!=0)). A same-cycle wb_valid on the matching register does not clear the hazard; the check uses the pre-edge count.
- waw_full = dec_valid && dec_writes_rd && dec_rd!=0 && cnt[dec_rd]==max.
- Flush FSM:
  - States: RUN and FLUSH.
  - RUN -> FLUSH on ex_redirect, loading the counter with FLUSH_CYCLES-1. If FLUSH_CYCLES==1 the FSM stays in RUN; the flush is still asserted that cycle.
  - FLUSH: counter decrements each cycle; FLUSH -> RUN when the counter is 0 and there is no new redirect.
  - ex_redirect while in FLUSH reloads the counter.
  - flush_busy=1 in FLUSH.
- Priority, highest first (exactly one row applies):
  1. ex_redirect or state FLUSH: flush_fetch=flush_decode=1, issue=0, stalls=0.
  2. mem_stall: stall_fetch=stall_decode=stall_execute=1, issue=0.
  3. ex_busy: stall_fetch=stall_decode=1, issue=0.
  4. raw_hazard or waw_full: stall_fetch=stall_decode=1, flush_execute=1 (bubble), issue=0.
  5. Otherwise: issue=dec_valid, no stalls or flushes.
- mem_stall concurrent with ex_redirect: the redirect wins. The execute stage is not stalled, and redirect ownership lies with execute.
- wb_valid is honoured in every row, including stall rows.

Optional Feature:
PIPE_PERF_EN:
- Defined: adds outputs perf_stall_cycles, perf_hazard_cycles and perf_flush_events, each 32 bits.
  - perf_stall_cycles counts cycles in rows 2-4.
  - perf_hazard_cycles counts cycles in row 4.
  - perf_flush_events counts ex_redirect pulses.
  - All counters wrap at 2^32, clear on reset, and are read-only.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- params.v additions: `PCTRL_RUN / `PCTRL_FLUSH state encodings, `FLUSH_CYCLES default, `SB_CNT_SIZE; reuse the existing `REG_ADDR_SIZE.
- Sub-module reg_scoreboard:
  - Inputs: counter array, inc/dec ports.
  - Outputs: two read ports for rs1/rs2, plus a full flag for rd.
- The top-level holds the flush FSM, the priority mux and the perf counters.

Test Plan:
- Issue x5 writer (dec_rd=5), next cycle decode reads rs1=5 -> stall_fetch=stall_decode=1, flush_execute=1, issue=0; wb_valid wb_rd=5 -> issue=1 the following cycle.
- Three back-to-back writers of x7 with CNT_W=2, no writeback -> third issues (cnt=3), fourth writer stalls on waw_full until one wb_valid on x7.
- ex_redirect pulse with FLUSH_CYCLES=3 -> flush_fetch/flush_decode high 3 cycles; second redirect on cycle 2 extends to cycle 4; issue=0 throughout.
- mem_stall=1 with ex_redirect=1 same cycle -> only flushes asserted; mem_stall alone -> all three stalls=1; wb_valid for x3 during stall decrements cnt[3].
- Same-cycle issue of writer x9 and wb_valid x9 with cnt[9]=1 -> cnt[9] stays 1; dec_rd=0 writers never stall, never count.
- Reset asserted during FLUSH with cnt[4]=2 -> next cycle FSM RUN, cnt[4]=0, read of x4 issues immediately; with PIPE_PERF_EN, all perf counters read 0.
